// File: rtl/mips_decode_stage.sv
// ============================================================================
// mips_decode_stage : MIPS ID stage (decoder, GPR file, early branch/jump
//                     resolution, ID/EX register). Option: MIPS_DECODE_JUMP_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module mips_decode_stage #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int RA_IDX = 31
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_d,
    input  logic            flush_e,
    input  logic [31:0]     instr_d,
    input  logic [XLEN-1:0] pc_plus4_d,
    input  logic            forward_ad,
    input  logic            forward_bd,
    input  logic [XLEN-1:0] alu_out_m,
    input  logic            reg_write_w,
    input  logic [4:0]      write_reg_w,
    input  logic [XLEN-1:0] result_w,
    output logic            pcsrc_d,
    output logic [XLEN-1:0] pc_branch_d,
    output logic            illegal_d,
    output logic            valid_e,
    output logic            reg_write_e,
    output logic            mem_to_reg_e,
    output logic            mem_write_e,
    output logic            alu_src_e,
    output logic            reg_dst_e,
    output logic [2:0]      alu_ctrl_e,
    output logic [4:0]      rs_e,
    output logic [4:0]      rt_e,
    output logic [4:0]      rd_e,
    output logic [4:0]      shamt_e,
    output logic [XLEN-1:0] rd1_e,
    output logic [XLEN-1:0] rd2_e,
    output logic [XLEN-1:0] imm_e,
    output logic [XLEN-1:0] pc_plus4_e
);

`ifdef MIPS_DECODE_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SRL   = 6'b000010;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b111;
    localparam logic [2:0] ALU_SLL  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_to_reg;
        logic            mem_write;
        logic            alu_src;
        logic            reg_dst;
        logic [2:0]      alu_ctrl;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc_plus4;
    } ex_t;

    logic [5:0]      op;
    logic [5:0]      funct;
    logic [4:0]      rs_f;
    logic [4:0]      rt_f;
    logic [4:0]      rd_f;
    logic [4:0]      shamt_f;
    logic [XLEN-1:0] imm_ext;

    assign op      = instr_d[31:26];
    assign rs_f    = instr_d[25:21];
    assign rt_f    = instr_d[20:16];
    assign rd_f    = instr_d[15:11];
    assign shamt_f = instr_d[10:6];
    assign funct   = instr_d[5:0];
    assign imm_ext = {{(XLEN-16){instr_d[15]}}, instr_d[15:0]};

    // ------------------------------------------------------------------
    // Register file: r0 is not stored; indices >= NREG read as zero
    // ------------------------------------------------------------------
    logic [XLEN-1:0] gpr_q [1:NREG-1];
    logic [XLEN-1:0] gpr_d [1:NREG-1];
    logic            wb_en;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;

    assign wb_en = reg_write_w && (write_reg_w != 5'd0) && ({1'b0, write_reg_w} < 6'(NREG));

    always_comb begin
        gpr_d = gpr_q;
        for (int i = 1; i < NREG; i++) begin
            if (wb_en && (write_reg_w == 5'(i))) begin
                gpr_d[i] = result_w;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREG; i++) begin
                gpr_q[i] <= '0;
            end
        end else begin
            gpr_q <= gpr_d;
        end
    end

    // Write-first read: a same-cycle WB to the read index wins over the stored value
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        for (int i = 1; i < NREG; i++) begin
            if (rs_f == 5'(i)) rd1 = gpr_q[i];
            if (rt_f == 5'(i)) rd2 = gpr_q[i];
        end
        if (wb_en && (write_reg_w == rs_f)) rd1 = result_w;
        if (wb_en && (write_reg_w == rt_f)) rd2 = result_w;
    end

    // ------------------------------------------------------------------
    // Main decoder
    // ------------------------------------------------------------------
    logic       illegal;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_ctrl;
    logic       is_beq;
    logic       is_bne;
    logic       is_j;
    logic       is_jal;
    logic       is_jr;

    always_comb begin
        illegal    = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src    = 1'b0;
        reg_dst    = 1'b0;
        alu_ctrl   = ALU_AND;
        is_beq     = 1'b0;
        is_bne     = 1'b0;
        is_j       = 1'b0;
        is_jal     = 1'b0;
        is_jr      = 1'b0;
        case (op)
            OP_RTYPE: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                case (funct)
                    FN_ADD: alu_ctrl = ALU_ADD;
                    FN_SUB: alu_ctrl = ALU_SUB;
                    FN_AND: alu_ctrl = ALU_AND;
                    FN_OR:  alu_ctrl = ALU_OR;
                    FN_SLT: alu_ctrl = ALU_SLT;
                    FN_SLL: alu_ctrl = ALU_SLL;
                    FN_SRL: alu_ctrl = ALU_SRL;
                    FN_JR: begin
                        reg_write = 1'b0;
                        reg_dst   = 1'b0;
                        if (JUMP_EN) is_jr = 1'b1;
                        else         illegal = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin
                reg_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = ALU_ADD;
            end
            OP_LW: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                alu_src    = 1'b1;
                alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                mem_write = 1'b1;
                alu_src   = 1'b1;
                alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                is_beq   = 1'b1;
                alu_ctrl = ALU_SUB;
            end
            OP_BNE: begin
                is_bne   = 1'b1;
                alu_ctrl = ALU_SUB;
            end
            OP_J: begin
                if (JUMP_EN) is_j = 1'b1;
                else         illegal = 1'b1;
            end
            OP_JAL: begin
                if (JUMP_EN) begin
                    is_jal    = 1'b1;
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    alu_src   = 1'b1;
                    alu_ctrl  = ALU_ADD;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            mem_write  = 1'b0;
            alu_src    = 1'b0;
            reg_dst    = 1'b0;
            alu_ctrl   = ALU_AND;
        end
    end

    assign illegal_d = illegal;

    // ------------------------------------------------------------------
    // Early branch / jump resolution
    // ------------------------------------------------------------------
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b;
    logic            taken;

    assign src_a = forward_ad ? alu_out_m : rd1;
    assign src_b = forward_bd ? alu_out_m : rd2;
    assign taken = (is_beq && (src_a == src_b)) || (is_bne && (src_a != src_b))
                 || is_j || is_jal || is_jr;
    assign pcsrc_d = rst_n && !stall_d && taken;

    always_comb begin
        pc_branch_d = pc_plus4_d + (imm_ext << 2);
        if (is_j || is_jal) begin
            pc_branch_d = {pc_plus4_d[XLEN-1:28], instr_d[25:0], 2'b00};
        end else if (is_jr) begin
            pc_branch_d = src_a;
        end
    end

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    ex_t ex_d;
    ex_t ex_q;

    always_comb begin
        ex_d = '0;
        if (!(flush_e || stall_d)) begin
            ex_d.valid      = !illegal;
            ex_d.reg_write  = reg_write;
            ex_d.mem_to_reg = mem_to_reg;
            ex_d.mem_write  = mem_write;
            ex_d.alu_src    = alu_src;
            ex_d.reg_dst    = reg_dst;
            ex_d.alu_ctrl   = alu_ctrl;
            ex_d.rs         = rs_f;
            ex_d.rt         = rt_f;
            ex_d.rd         = rd_f;
            ex_d.shamt      = shamt_f;
            ex_d.rd1        = rd1;
            ex_d.rd2        = rd2;
            ex_d.imm        = imm_ext;
            ex_d.pc_plus4   = pc_plus4_d;
            // JAL computes the link value in EX as 0 + pc_plus4 through the ALU
            if (is_jal) begin
                ex_d.rd  = 5'(RA_IDX);
                ex_d.rs  = 5'd0;
                ex_d.rd1 = '0;
                ex_d.imm = pc_plus4_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign valid_e      = ex_q.valid;
    assign reg_write_e  = ex_q.reg_write;
    assign mem_to_reg_e = ex_q.mem_to_reg;
    assign mem_write_e  = ex_q.mem_write;
    assign alu_src_e    = ex_q.alu_src;
    assign reg_dst_e    = ex_q.reg_dst;
    assign alu_ctrl_e   = ex_q.alu_ctrl;
    assign rs_e         = ex_q.rs;
    assign rt_e         = ex_q.rt;
    assign rd_e         = ex_q.rd;
    assign shamt_e      = ex_q.shamt;
    assign rd1_e        = ex_q.rd1;
    assign rd2_e        = ex_q.rd2;
    assign imm_e        = ex_q.imm;
    assign pc_plus4_e   = ex_q.pc_plus4;

endmodule

`default_nettype wire

// File: tb/tb_mips_decode_stage.sv
// Directed self-checking bench for mips_decode_stage (default parameters).
`default_nettype none

module tb_mips_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_d;
    logic        flush_e;
    logic [31:0] instr_d;
    logic [31:0] pc_plus4_d;
    logic        forward_ad;
    logic        forward_bd;
    logic [31:0] alu_out_m;
    logic        reg_write_w;
    logic [4:0]  write_reg_w;
    logic [31:0] result_w;
    logic        pcsrc_d;
    logic [31:0] pc_branch_d;
    logic        illegal_d;
    logic        valid_e, reg_write_e, mem_to_reg_e, mem_write_e, alu_src_e, reg_dst_e;
    logic [2:0]  alu_ctrl_e;
    logic [4:0]  rs_e, rt_e, rd_e, shamt_e;
    logic [31:0] rd1_e, rd2_e, imm_e, pc_plus4_e;

    int errors = 0;
    int checks = 0;

    mips_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .stall_d(stall_d), .flush_e(flush_e),
        .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
        .forward_ad(forward_ad), .forward_bd(forward_bd), .alu_out_m(alu_out_m),
        .reg_write_w(reg_write_w), .write_reg_w(write_reg_w), .result_w(result_w),
        .pcsrc_d(pcsrc_d), .pc_branch_d(pc_branch_d), .illegal_d(illegal_d),
        .valid_e(valid_e), .reg_write_e(reg_write_e), .mem_to_reg_e(mem_to_reg_e),
        .mem_write_e(mem_write_e), .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e),
        .alu_ctrl_e(alu_ctrl_e), .rs_e(rs_e), .rt_e(rt_e), .rd_e(rd_e), .shamt_e(shamt_e),
        .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e), .pc_plus4_e(pc_plus4_e)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_ins(input logic [5:0] op, input logic [25:0] t);
        return {op, t};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] idx, input logic [31:0] val);
        instr_d     = 32'h0;
        reg_write_w = 1'b1;
        write_reg_w = idx;
        result_w    = val;
        tick();
        reg_write_w = 1'b0;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        instr_d = i_ins(6'h04, 5'd0, 5'd0, 16'd1);
        pc_plus4_d = 32'h100;
        repeat (3) tick();
        checks++; if (pcsrc_d !== 1'b0) begin errors++; $display("FAIL reset_pcsrc: got %b want 0", pcsrc_d); end
        checks++; if (valid_e !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_e); end
        checks++; if ({reg_write_e, alu_ctrl_e, rs_e, imm_e, pc_plus4_e} !== '0) begin
            errors++; $display("FAIL reset_ex: got rw=%b alu=%b rs=%0d imm=%h pc4=%h want all 0",
                               reg_write_e, alu_ctrl_e, rs_e, imm_e, pc_plus4_e); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (pcsrc_d !== 1'b1) begin errors++; $display("FAIL post_reset_beq_r0: got %b want 1", pcsrc_d); end
        instr_d = r_ins(5'd5, 5'd0, 5'd6, 5'd0, 6'h20);
        tick();
        checks++; if (rd1_e !== 32'h0) begin errors++; $display("FAIL reset_r5: got %h want 0", rd1_e); end
    endtask

    task automatic test_wb_bypass();
        instr_d     = r_ins(5'd5, 5'd0, 5'd6, 5'd0, 6'h20);
        reg_write_w = 1'b1;
        write_reg_w = 5'd5;
        result_w    = 32'h1234;
        tick();
        reg_write_w = 1'b0;
        checks++; if (rd1_e !== 32'h1234) begin errors++; $display("FAIL bypass_rd1: got %h want 1234", rd1_e); end
        checks++; if ({rs_e, rd_e} !== {5'd5, 5'd6}) begin errors++; $display("FAIL bypass_fields: got rs=%0d rd=%0d want 5 6", rs_e, rd_e); end
        checks++; if ({valid_e, reg_write_e, reg_dst_e, alu_src_e, alu_ctrl_e} !== {4'b1110, 3'b010}) begin
            errors++; $display("FAIL bypass_ctrl: got v=%b rw=%b rdst=%b asrc=%b alu=%b want 1 1 1 0 010",
                               valid_e, reg_write_e, reg_dst_e, alu_src_e, alu_ctrl_e); end
        result_w = 32'hDEAD;
        tick();
        checks++; if (rd1_e !== 32'h1234) begin errors++; $display("FAIL stored_r5: got %h want 1234", rd1_e); end
    endtask

    task automatic test_alu_ctrl();
        logic [5:0] fn  [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h00, 6'h02};
        logic [2:0] exp [7] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b100, 3'b101};
        for (int i = 0; i < 7; i++) begin
            instr_d = r_ins(5'd1, 5'd2, 5'd3, 5'd4, fn[i]);
            tick();
            checks++; if (alu_ctrl_e !== exp[i] || shamt_e !== 5'd4 || valid_e !== 1'b1) begin
                errors++; $display("FAIL alu_ctrl fn=%h: got alu=%b sh=%0d v=%b want %b 4 1",
                                   fn[i], alu_ctrl_e, shamt_e, valid_e, exp[i]); end
        end
    endtask

    task automatic test_branch();
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd7);
        instr_d    = i_ins(6'h04, 5'd1, 5'd2, 16'd3);
        pc_plus4_d = 32'h100;
        #1;
        checks++; if (pcsrc_d !== 1'b1 || pc_branch_d !== 32'h10C) begin
            errors++; $display("FAIL beq_taken: got pcsrc=%b tgt=%h want 1 10c", pcsrc_d, pc_branch_d); end
        forward_ad = 1'b1;
        alu_out_m  = 32'd8;
        #1;
        checks++; if (pcsrc_d !== 1'b0) begin errors++; $display("FAIL beq_fwd: got %b want 0", pcsrc_d); end
        instr_d = i_ins(6'h05, 5'd1, 5'd2, 16'hFFFF);
        #1;
        checks++; if (pcsrc_d !== 1'b1 || pc_branch_d !== 32'hFC) begin
            errors++; $display("FAIL bne_neg: got pcsrc=%b tgt=%h want 1 fc", pcsrc_d, pc_branch_d); end
        forward_ad = 1'b0;
        forward_bd = 1'b1;
        #1;
        checks++; if (pcsrc_d !== 1'b1) begin errors++; $display("FAIL bne_fwd_b: got %b want 1", pcsrc_d); end
        forward_bd = 1'b0;
        #1;
        checks++; if (pcsrc_d !== 1'b0) begin errors++; $display("FAIL bne_equal: got %b want 0", pcsrc_d); end
        instr_d = i_ins(6'h04, 5'd1, 5'd2, 16'd3);
        stall_d = 1'b1;
        #1;
        checks++; if (pcsrc_d !== 1'b0) begin errors++; $display("FAIL beq_stall: got %b want 0", pcsrc_d); end
        stall_d = 1'b0;
        tick();
        checks++; if ({valid_e, reg_write_e, rd1_e, rd2_e} !== {2'b10, 32'd7, 32'd7}) begin
            errors++; $display("FAIL beq_ex: got v=%b rw=%b rd1=%h rd2=%h want 1 0 7 7",
                               valid_e, reg_write_e, rd1_e, rd2_e); end
        instr_d = i_ins(6'h2B, 5'd1, 5'd2, 16'd4);
        tick();
        checks++; if ({mem_write_e, reg_write_e, alu_src_e, imm_e} !== {3'b101, 32'd4}) begin
            errors++; $display("FAIL sw_ex: got mw=%b rw=%b as=%b imm=%h want 1 0 1 4",
                               mem_write_e, reg_write_e, alu_src_e, imm_e); end
    endtask

    task automatic test_jump();
        instr_d    = j_ins(6'h03, 26'h40);
        pc_plus4_d = 32'h204;
        #1;
`ifdef MIPS_DECODE_JUMP_EN
        checks++; if (pcsrc_d !== 1'b1 || pc_branch_d !== 32'h100 || illegal_d !== 1'b0) begin
            errors++; $display("FAIL jal_redirect: got pcsrc=%b tgt=%h ill=%b want 1 100 0", pcsrc_d, pc_branch_d, illegal_d); end
        tick();
        checks++; if ({rd_e, rs_e, imm_e, rd1_e} !== {5'd31, 5'd0, 32'h204, 32'h0}) begin
            errors++; $display("FAIL jal_ex: got rd=%0d rs=%0d imm=%h rd1=%h want 31 0 204 0", rd_e, rs_e, imm_e, rd1_e); end
        checks++; if ({valid_e, reg_write_e, reg_dst_e, alu_src_e, alu_ctrl_e} !== {4'b1111, 3'b010}) begin
            errors++; $display("FAIL jal_ctrl: got v=%b rw=%b rdst=%b as=%b alu=%b want 1 1 1 1 010",
                               valid_e, reg_write_e, reg_dst_e, alu_src_e, alu_ctrl_e); end
        instr_d = r_ins(5'd1, 5'd0, 5'd0, 5'd0, 6'h08);
        #1;
        checks++; if (pcsrc_d !== 1'b1 || pc_branch_d !== 32'd7) begin
            errors++; $display("FAIL jr_redirect: got pcsrc=%b tgt=%h want 1 7", pcsrc_d, pc_branch_d); end
`else
        checks++; if (pcsrc_d !== 1'b0 || illegal_d !== 1'b1) begin
            errors++; $display("FAIL jal_disabled: got pcsrc=%b ill=%b want 0 1", pcsrc_d, illegal_d); end
        tick();
        checks++; if ({valid_e, reg_write_e, alu_src_e} !== 3'b000) begin
            errors++; $display("FAIL jal_disabled_ex: got v=%b rw=%b as=%b want 0 0 0", valid_e, reg_write_e, alu_src_e); end
        instr_d = r_ins(5'd1, 5'd0, 5'd0, 5'd0, 6'h08);
        #1;
        checks++; if (pcsrc_d !== 1'b0 || illegal_d !== 1'b1) begin
            errors++; $display("FAIL jr_disabled: got pcsrc=%b ill=%b want 0 1", pcsrc_d, illegal_d); end
`endif
        tick();
    endtask

    task automatic test_r0_illegal();
        instr_d     = r_ins(5'd0, 5'd0, 5'd6, 5'd0, 6'h20);
        reg_write_w = 1'b1;
        write_reg_w = 5'd0;
        result_w    = 32'hFFFF;
        #1;
        checks++; if (illegal_d !== 1'b0) begin errors++; $display("FAIL add_legal: got %b want 0", illegal_d); end
        tick();
        reg_write_w = 1'b0;
        checks++; if (rd1_e !== 32'h0) begin errors++; $display("FAIL r0_bypass: got %h want 0", rd1_e); end
        tick();
        checks++; if (rd1_e !== 32'h0) begin errors++; $display("FAIL r0_stored: got %h want 0", rd1_e); end
        instr_d = 32'hFC00_0000;
        #1;
        checks++; if (illegal_d !== 1'b1) begin errors++; $display("FAIL op3f_illegal: got %b want 1", illegal_d); end
        tick();
        checks++; if ({valid_e, reg_write_e} !== 2'b00) begin
            errors++; $display("FAIL op3f_ex: got v=%b rw=%b want 0 0", valid_e, reg_write_e); end
        instr_d = r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h3F);
        #1;
        checks++; if (illegal_d !== 1'b1) begin errors++; $display("FAIL funct3f_illegal: got %b want 1", illegal_d); end
    endtask

    task automatic test_bubble();
        instr_d    = i_ins(6'h23, 5'd1, 5'd3, 16'd8);
        pc_plus4_d = 32'h300;
        flush_e    = 1'b1;
        stall_d    = 1'b1;
        #1;
        checks++; if (pcsrc_d !== 1'b0) begin errors++; $display("FAIL bubble_pcsrc: got %b want 0", pcsrc_d); end
        tick();
        checks++; if ({valid_e, mem_to_reg_e, reg_write_e, alu_src_e, rs_e, rt_e, imm_e, rd1_e, pc_plus4_e} !== '0) begin
            errors++; $display("FAIL bubble_ex: got v=%b m2r=%b rw=%b imm=%h rd1=%h pc4=%h want all 0",
                               valid_e, mem_to_reg_e, reg_write_e, imm_e, rd1_e, pc_plus4_e); end
        flush_e = 1'b0;
        tick();
        checks++; if (valid_e !== 1'b0) begin errors++; $display("FAIL stall_only_bubble: got %b want 0", valid_e); end
        stall_d = 1'b0;
        tick();
        checks++; if ({valid_e, mem_to_reg_e, reg_write_e, alu_src_e, reg_dst_e} !== 5'b11110) begin
            errors++; $display("FAIL lw_ctrl: got v=%b m2r=%b rw=%b as=%b rdst=%b want 1 1 1 1 0",
                               valid_e, mem_to_reg_e, reg_write_e, alu_src_e, reg_dst_e); end
        checks++; if ({rt_e, imm_e, rd1_e, pc_plus4_e} !== {5'd3, 32'd8, 32'd7, 32'h300}) begin
            errors++; $display("FAIL lw_fields: got rt=%0d imm=%h rd1=%h pc4=%h want 3 8 7 300",
                               rt_e, imm_e, rd1_e, pc_plus4_e); end
    endtask

    task automatic test_async_reset();
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({valid_e, reg_write_e, rd1_e, imm_e} !== '0) begin
            errors++; $display("FAIL async_reset: got v=%b rw=%b rd1=%h imm=%h want all 0",
                               valid_e, reg_write_e, rd1_e, imm_e); end
        @(negedge clk);
        rst_n   = 1'b1;
        instr_d = r_ins(5'd1, 5'd5, 5'd6, 5'd0, 6'h20);
        tick();
        checks++; if ({rd1_e, rd2_e} !== 64'h0) begin
            errors++; $display("FAIL gpr_cleared: got rd1=%h rd2=%h want 0 0", rd1_e, rd2_e); end
    endtask

    initial begin
        rst_n       = 1'b0;
        stall_d     = 1'b0;
        flush_e     = 1'b0;
        instr_d     = 32'h0;
        pc_plus4_d  = 32'h0;
        forward_ad  = 1'b0;
        forward_bd  = 1'b0;
        alu_out_m   = 32'h0;
        reg_write_w = 1'b0;
        write_reg_w = 5'd0;
        result_w    = 32'h0;
        test_reset();
        test_wb_bypass();
        test_alu_ctrl();
        test_branch();
        test_jump();
        test_r0_illegal();
        test_bubble();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
